mc_control: RTL and testbench

Main control FSM for the multicycle RV32I-subset CPU; sits directly upstream of ALUcontrol and drives its `ALUop`, plus every datapath enable and mux select. Supports add/sub (R-type), addi, lw, sw, beq, jal; one state per datapath step, Moore outputs. An illegal opcode parks the FSM in a sticky error state.

---
 rtl/mc_control_pkg.sv | 54 +++++
 rtl/mc_control_opcode_class.sv | 23 ++
 rtl/mc_control.sv | 160 ++++++++++++++++
 tb/tb_mc_control.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mc_control_pkg.sv
// Shared encodings for the multicycle CPU control path: FSM states, opcodes,
// ALUop codes, datapath mux selects and the decoded instruction class.
package mc_control_pkg;

  typedef enum logic [3:0] {
    S_IF       = 4'd0,
    S_ID       = 4'd1,
    S_EX_R     = 4'd2,
    S_EX_I     = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ERR      = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_I       = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_BEQ     = 3'd4,
    CLS_JAL     = 3'd5,
    CLS_ILLEGAL = 3'd6
  } op_class_t;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // ALUop codes are shared with ALUcontrol
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] MTR_ALUOUT = 2'b00;
  localparam logic [1:0] MTR_MDR    = 2'b01;
  localparam logic [1:0] MTR_PC     = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_A     = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;

endpackage

// File: rtl/mc_control_opcode_class.sv
// Combinational opcode -> instruction-class decode used by the ID and
// MEM_ADDR transitions of mc_control.
module opcode_class
  import mc_control_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  cls
);

  always_comb begin
    cls = CLS_ILLEGAL;
    case (opcode)
      OP_RTYPE: cls = CLS_R;
      OP_ITYPE: cls = CLS_I;
      OP_LOAD:  cls = CLS_LOAD;
      OP_STORE: cls = CLS_STORE;
      OP_BEQ:   cls = CLS_BEQ;
      OP_JAL:   cls = CLS_JAL;
      default:  cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Main control FSM of the multicycle RV32I-subset CPU: one state per datapath
// step, Moore outputs (PCWrite in S_BEQ additionally follows the zero flag).
module mc_control
  import mc_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       zero,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUop,
  output logic       PCSource,
  output logic       instr_done,
  output logic       illegal
);

  state_t    state;
  state_t    next_state;
  op_class_t cls;

  logic pc_write;
  logic mem_write;
  logic ir_write;
  logic reg_write;
  logic done;
  logic err;

  opcode_class u_opcode_class (
    .opcode (opcode),
    .cls    (cls)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IF;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    pc_write   = 1'b0;
    IorD       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    MemtoReg   = MTR_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_B;
    ALUop      = ALUOP_ADD;
    PCSource   = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      S_IF: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        ALUSrcB    = SRCB_4;
        next_state = S_ID;
      end
      // ALUOut captures oldPC + imm here: the beq/jal target
      S_ID: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (cls)
          CLS_R:     next_state = S_EX_R;
          CLS_I:     next_state = S_EX_I;
          CLS_LOAD:  next_state = S_MEM_ADDR;
          CLS_STORE: next_state = S_MEM_ADDR;
          CLS_BEQ:   next_state = S_BEQ;
          CLS_JAL:   next_state = S_JAL;
          default:   next_state = S_ERR;
        endcase
      end
      S_EX_R: begin
        ALUSrcA    = SRCA_A;
        ALUop      = ALUOP_FUNCT;
        next_state = S_WB_ALU;
      end
      // addi forces add so imm bit 30 can never select sub
      S_EX_I: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_IMM;
        next_state = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_write  = 1'b1;
        done       = 1'b1;
        next_state = S_IF;
      end
      S_MEM_ADDR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        if (cls == CLS_LOAD) begin
          next_state = S_MEM_RD;
        end else begin
          next_state = S_MEM_WR;
        end
      end
      S_MEM_RD: begin
        IorD       = 1'b1;
        next_state = S_WB_MEM;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        MemtoReg   = MTR_MDR;
        done       = 1'b1;
        next_state = S_IF;
      end
      S_MEM_WR: begin
        IorD       = 1'b1;
        mem_write  = 1'b1;
        done       = 1'b1;
        next_state = S_IF;
      end
      S_BEQ: begin
        ALUSrcA    = SRCA_A;
        ALUop      = ALUOP_SUB;
        PCSource   = 1'b1;
        pc_write   = zero;
        done       = 1'b1;
        next_state = S_IF;
      end
      // PC already holds oldPC+4, which is the link value
      S_JAL: begin
        PCSource   = 1'b1;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        MemtoReg   = MTR_PC;
        done       = 1'b1;
        next_state = S_IF;
      end
      S_ERR: begin
        err        = 1'b1;
        next_state = S_ERR;
      end
      default: begin
        err        = 1'b1;
        next_state = S_ERR;
      end
    endcase
  end

  // Reset suppresses every side effect in the same cycle it is asserted
  assign PCWrite    = pc_write  & ~rst;
  assign MemWrite   = mem_write & ~rst;
  assign IRWrite    = ir_write  & ~rst;
  assign RegWrite   = reg_write & ~rst;
  assign instr_done = done      & ~rst;
  assign illegal    = err       & ~rst;

endmodule

// File: tb/tb_mc_control.sv
// Randomized bench for mc_control: a per-instruction step model predicts the
// full control vector every cycle, including random resets and illegal opcodes.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       zero;
  logic       PCWrite, IorD, MemWrite, IRWrite, RegWrite;
  logic [1:0] MemtoReg, ALUSrcA, ALUSrcB, ALUop;
  logic       PCSource, instr_done, illegal;

  int n_checks = 0;
  int n_fail   = 0;

  mc_control dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .PCWrite    (PCWrite),
    .IorD       (IorD),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .MemtoReg   (MemtoReg),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUop      (ALUop),
    .PCSource   (PCSource),
    .instr_done (instr_done),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // Instruction kinds of the reference model
  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_JAL = 5, K_ILL = 6;

  // Bits that are defined during reset: all enables, instr_done, illegal
  localparam logic [15:0] RST_MASK = 16'b1011_1000_0000_0011;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] pk(input logic pcw, input logic iord, input logic mw,
                                     input logic irw, input logic rw, input logic [1:0] mtr,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] op, input logic ps,
                                     input logic dn, input logic il);
    return {pcw, iord, mw, irw, rw, mtr, sa, sb, op, ps, dn, il};
  endfunction

  function automatic int classify(input logic [6:0] op);
    case (op)
      7'h33:   return K_R;
      7'h13:   return K_I;
      7'h03:   return K_LW;
      7'h23:   return K_SW;
      7'h63:   return K_BEQ;
      7'h6F:   return K_JAL;
      default: return K_ILL;
    endcase
  endfunction

  function automatic int cpi(input int kind);
    case (kind)
      K_LW:          return 5;
      K_BEQ, K_JAL:  return 3;
      default:       return 4;
    endcase
  endfunction

  // Expected control vector for step k (0 = fetch) of an instruction of this kind
  function automatic logic [15:0] expect_vec(input int kind, input int k, input logic z);
    if (k == 0) return pk(1'b1,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b01,2'b00,1'b0,1'b0,1'b0);
    if (k == 1) return pk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b10,2'b00,1'b0,1'b0,1'b0);
    case (kind)
      K_R:   return (k == 2) ? pk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b00,2'b10,1'b0,1'b0,1'b0)
                             : pk(1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,1'b0,1'b1,1'b0);
      K_I:   return (k == 2) ? pk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b10,2'b00,1'b0,1'b0,1'b0)
                             : pk(1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,1'b0,1'b1,1'b0);
      K_LW:  return (k == 2) ? pk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b10,2'b00,1'b0,1'b0,1'b0)
                  : (k == 3) ? pk(1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0)
                             : pk(1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b00,2'b00,2'b00,1'b0,1'b1,1'b0);
      K_SW:  return (k == 2) ? pk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b10,2'b00,1'b0,1'b0,1'b0)
                             : pk(1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b1,1'b0);
      K_BEQ: return pk(z,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b00,2'b01,1'b1,1'b1,1'b0);
      K_JAL: return pk(1'b1,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,2'b00,1'b1,1'b1,1'b0);
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [6:0] pick_opcode();
    logic [6:0] op;
    int sel;
    sel = $urandom_range(0, 13);
    case (sel)
      0, 1:   op = 7'h33;
      2, 3:   op = 7'h13;
      4, 5:   op = 7'h03;
      6, 7:   op = 7'h23;
      8, 9:   op = 7'h63;
      10, 11: op = 7'h6F;
      default: begin
        op = 7'($urandom_range(0, 127));
        while (classify(op) != K_ILL) op = 7'($urandom_range(0, 127));
      end
    endcase
    return op;
  endfunction

  initial begin
    int k;
    int kind;
    bit err;
    int retired_model;
    int retired_dut;
    logic [15:0] got;
    logic [15:0] exp;
    string tag;

    k = 0; kind = K_R; err = 1'b0;
    retired_model = 0; retired_dut = 0;
    rst = 1'b1; opcode = 7'h33; zero = 1'b0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (cyc < 3) begin
        rst = 1'b1;
        opcode = 7'h33;
      end else begin
        rst = ($urandom_range(0, 99) < 3);
        if (k == 0 && !err) opcode = pick_opcode();
      end
      zero = 1'($urandom_range(0, 1));
      #2;
      got = {PCWrite, IorD, MemWrite, IRWrite, RegWrite, MemtoReg, ALUSrcA, ALUSrcB,
             ALUop, PCSource, instr_done, illegal};
      if (rst) begin
        check_eq("reset", got & RST_MASK, 16'h0000);
      end else if (err) begin
        check_eq("err_state", got, pk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b1));
      end else begin
        exp = expect_vec(kind, k, zero);
        tag = $sformatf("op%02h_step%0d", opcode, k);
        check_eq(tag, got, exp);
      end
      if (instr_done === 1'b1) retired_dut++;

      @(posedge clk);
      if (rst) begin
        k = 0;
        err = 1'b0;
      end else if (err) begin
        err = 1'b1;
      end else if (k == 0) begin
        k = 1;
      end else if (k == 1) begin
        kind = classify(opcode);
        if (kind == K_ILL) err = 1'b1;
        else k = 2;
      end else begin
        k++;
        if (k == cpi(kind)) begin
          k = 0;
          retired_model++;
        end
      end
    end

    check_eq("retired_count", 16'(retired_dut), 16'(retired_model));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
